md_scheduler: RTL and testbench

- Multiply/divide scheduler for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E stage and runs them over a fixed multi-cycle latency.
- Owns the HI/LO registers and raises a stall request so the hazard unit can freeze the D/E pipeline-register enables while a younger HI/LO-dependent instruction would collide with an in-flight operation.

---
 rtl/md_scheduler.sv | 178 +++++++++++++++++
 tb/tb_md_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler for the 5-stage MIPS pipeline.
// Owns HI/LO, runs mult/div over a fixed latency and requests D/E stalls.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic        E_start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_mf_sel,
    input  logic        D_md_use,
    output logic [31:0] E_md_out,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic        w_issue_md;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_zero;
    logic [31:0] w_dvsr;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    assign busy     = (r_state == S_RUN);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign E_md_out = E_mf_sel ? r_lo : r_hi;

    assign w_issue_md = E_start &
                        ((E_md_op == OP_MULT) | (E_md_op == OP_MULTU) |
                         (E_md_op == OP_DIV)  | (E_md_op == OP_DIVU));
    assign md_stall   = D_md_use & (busy | w_issue_md);

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) *
                      $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Zero divisor is replaced by 1 so the dividers never see it; result is discarded.
    assign w_div_zero = (r_b == 32'd0);
    assign w_dvsr     = w_div_zero ? 32'd1 : r_b;

    assign w_q_u = r_a / w_dvsr;
    assign w_r_u = r_a % w_dvsr;

    // Signed divide via magnitudes: quotient truncates, remainder follows dividend.
    assign w_a_mag = r_a[31]    ? (32'd0 - r_a)    : r_a;
    assign w_b_mag = w_dvsr[31] ? (32'd0 - w_dvsr) : w_dvsr;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_q_s   = (r_a[31] ^ w_dvsr[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s   = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_we = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_we = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_we = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
                w_res_we = ~w_div_zero;
            end
            OP_DIVU: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
                w_res_we = ~w_div_zero;
            end
            default: begin
                w_res_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (E_start) begin
                        case (E_md_op)
                            OP_MULT, OP_MULTU: begin
                                r_a     <= E_A;
                                r_b     <= E_B;
                                r_op    <= E_md_op;
                                r_cnt   <= MULT_LOAD;
                                r_state <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a     <= E_A;
                                r_b     <= E_B;
                                r_op    <= E_md_op;
                                r_cnt   <= DIV_LOAD;
                                r_state <= S_RUN;
                            end
                            OP_MTHI: r_hi <= E_A;
                            OP_MTLO: r_lo <= E_A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // Issue attempts while running are dropped here.
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        if (w_res_we) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: latency, results, stall and reset.
// Expected values are hand-computed constants.
module tb_md_scheduler;

    logic        clk;
    logic        reset;
    logic [2:0]  E_md_op;
    logic        E_start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_mf_sel;
    logic        D_md_use;
    logic [31:0] E_md_out;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_md_op  (E_md_op),
        .E_start  (E_start),
        .E_A      (E_A),
        .E_B      (E_B),
        .E_mf_sel (E_mf_sel),
        .D_md_use (D_md_use),
        .E_md_out (E_md_out),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] val);
        E_md_op = op;
        E_A     = val;
        E_start = 1'b1;
        tick();
        E_start = 1'b0;
        E_md_op = 3'd0;
        check("mt_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int n;
        pre_hi  = HI;
        pre_lo  = LO;
        E_md_op = op;
        E_A     = a;
        E_B     = b;
        E_start = 1'b1;
        tick();
        E_start = 1'b0;
        E_md_op = 3'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            check({tag, "_hold_hi"}, HI, pre_hi);
            check({tag, "_hold_lo"}, LO, pre_lo);
            tick();
        end
        check({tag, "_cycles"}, n, exp_cyc);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        E_md_op  = 3'd0;
        E_start  = 1'b0;
        E_A      = 32'd0;
        E_B      = 32'd0;
        E_mf_sel = 1'b0;
        D_md_use = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_out", E_md_out, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", 3'd1, 32'd3, 32'hFFFF_FFFE, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_mt(3'd5, 32'h1111_1111);
        check("mthi", HI, 32'h1111_1111);
        do_mt(3'd6, 32'h2222_2222);
        check("mtlo", LO, 32'h2222_2222);
        run_op("div0", 3'd4, 32'd55, 32'd0, 10,
               32'h1111_1111, 32'h2222_2222);

        // Stall through a multu with an illegal mthi attempted mid-run
        D_md_use = 1'b1;
        E_md_op  = 3'd2;
        E_A      = 32'hFFFF_FFFF;
        E_B      = 32'd2;
        E_start  = 1'b1;
        #1;
        check("stall_issue", {31'd0, md_stall}, 32'd1);
        tick();
        E_start = 1'b0;
        E_md_op = 3'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            check("stall_busy", {31'd0, md_stall}, 32'd1);
            if (n == 2) begin
                E_md_op = 3'd5;
                E_A     = 32'hDEAD_BEEF;
                E_start = 1'b1;
                tick();
                E_start = 1'b0;
                E_md_op = 3'd0;
                check("illegal_mthi", HI, 32'h1111_1111);
            end else begin
                tick();
            end
        end
        check("stall_cycles", n, 32'd5);
        check("stall_release", {31'd0, md_stall}, 32'd0);
        check("multu_hi", HI, 32'd1);
        check("multu_lo", LO, 32'hFFFF_FFFE);
        D_md_use = 1'b0;

        // Asynchronous reset in the 4th busy cycle of div 100/7
        E_md_op = 3'd3;
        E_A     = 32'd100;
        E_B     = 32'd7;
        E_start = 1'b1;
        tick();
        E_start = 1'b0;
        E_md_op = 3'd0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);
        run_op("mult23", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6);

        do_mt(3'd5, 32'hAAAA_0000);
        do_mt(3'd6, 32'h0000_BBBB);
        E_mf_sel = 1'b0;
        #1;
        check("rd_hi", E_md_out, 32'hAAAA_0000);
        E_mf_sel = 1'b1;
        #1;
        check("rd_lo", E_md_out, 32'h0000_BBBB);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
